iobus_initiator: RTL and testbench

- Single-outstanding master for the MicroBlaze MCS IO bus. It turns a valid/ready command stream into one IO bus transaction and returns a valid/ready response.
- Sits opposite the IO bus responders, including the default responder, so fabric logic and benches can drive the bus without a processor.
- A bus watchdog completes any transaction that gets no io_ready, so a missing responder cannot hang the initiator.

---
 rtl/iobus_initiator.sv | 119 +++++++++++
 tb/tb_iobus_initiator.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/iobus_initiator.sv
// Single-outstanding MicroBlaze MCS IO bus master: one valid/ready command in,
// one IO bus transaction out, one valid/ready response back, with a bus watchdog.
module iobus_initiator #(
   parameter int TIMEOUT   = 255,
   parameter int CNT_WIDTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  logic [31:0] cmd_addr,
   input  logic [3:0]  cmd_be,
   input  logic [31:0] cmd_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_timeout,
   output logic        io_addr_strobe,
   output logic        io_read_strobe,
   output logic        io_write_strobe,
   output logic [31:0] io_address,
   output logic [3:0]  io_byte_enable,
   output logic [31:0] io_write_data,
   input  logic [31:0] io_read_data,
   input  logic        io_ready
);

   // state  | meaning
   // IDLE   | ready for a command
   // STROBE | single strobe cycle; io_ready may already answer here
   // WAIT   | strobe done, waiting for io_ready or the watchdog
   // RESP   | response presented, waiting for rsp_ready
   typedef enum logic [1:0] {IDLE, STROBE, WAIT, RESP} state_t;

   localparam logic [CNT_WIDTH-1:0] TERM_CNT = CNT_WIDTH'(TIMEOUT);

   state_t               state;
   logic                 is_write;
   logic [CNT_WIDTH-1:0] cnt;
   logic [CNT_WIDTH-1:0] cnt_next;
   logic                 timeout_hit;

   // cnt_next reaching TIMEOUT lands the response TIMEOUT+1 cycles after the strobe
   assign cnt_next    = cnt + CNT_WIDTH'(1);
   assign timeout_hit = (TIMEOUT != 0) && (cnt_next == TERM_CNT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= IDLE;
         is_write        <= 1'b0;
         cnt             <= '0;
         cmd_ready       <= 1'b0;
         rsp_valid       <= 1'b0;
         rsp_rdata       <= '0;
         rsp_timeout     <= 1'b0;
         io_addr_strobe  <= 1'b0;
         io_read_strobe  <= 1'b0;
         io_write_strobe <= 1'b0;
         io_address      <= '0;
         io_byte_enable  <= '0;
         io_write_data   <= '0;
      end else begin
         case (state)
            IDLE: begin
               cmd_ready <= 1'b1;
               if (cmd_valid && cmd_ready) begin
                  cmd_ready       <= 1'b0;
                  is_write        <= cmd_write;
                  io_address      <= cmd_addr;
                  io_byte_enable  <= cmd_write ? cmd_be : 4'hf;
                  io_write_data   <= cmd_wdata;
                  io_addr_strobe  <= 1'b1;
                  io_read_strobe  <= ~cmd_write;
                  io_write_strobe <= cmd_write;
                  state           <= STROBE;
               end
            end
            STROBE: begin
               io_addr_strobe  <= 1'b0;
               io_read_strobe  <= 1'b0;
               io_write_strobe <= 1'b0;
               if (io_ready) begin
                  rsp_valid   <= 1'b1;
                  rsp_timeout <= 1'b0;
                  rsp_rdata   <= is_write ? 32'h0 : io_read_data;
                  state       <= RESP;
               end else begin
                  cnt   <= '0;
                  state <= WAIT;
               end
            end
            WAIT: begin
               cnt <= cnt_next;
               if (io_ready) begin
                  rsp_valid   <= 1'b1;
                  rsp_timeout <= 1'b0;
                  rsp_rdata   <= is_write ? 32'h0 : io_read_data;
                  state       <= RESP;
               end else if (timeout_hit) begin
                  rsp_valid   <= 1'b1;
                  rsp_timeout <= 1'b1;
                  rsp_rdata   <= 32'hffff_ffff;
                  state       <= RESP;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  cmd_ready <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_iobus_initiator.sv
// Directed bench for iobus_initiator: vector table of single transactions plus
// hand sequences for back-pressure, stray io_ready and reset mid-transaction.
module tb_iobus_initiator;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_addr, cmd_wdata;
   logic [3:0]  cmd_be;
   logic        rsp_valid, rsp_ready, rsp_timeout;
   logic [31:0] rsp_rdata;
   logic        io_addr_strobe, io_read_strobe, io_write_strobe;
   logic [31:0] io_address, io_write_data, io_read_data;
   logic [3:0]  io_byte_enable;
   logic        io_ready;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   int          cur_dly  = 0;
   int          since    = 0;
   logic        stray    = 1'b0;
   logic [31:0] rd_data  = 32'h0;

   iobus_initiator #(.TIMEOUT(255), .CNT_WIDTH(8)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_be(cmd_be), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_timeout(rsp_timeout),
      .io_addr_strobe(io_addr_strobe), .io_read_strobe(io_read_strobe),
      .io_write_strobe(io_write_strobe), .io_address(io_address),
      .io_byte_enable(io_byte_enable), .io_write_data(io_write_data),
      .io_read_data(io_read_data), .io_ready(io_ready)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Responder model: dly 0 = default responder, dly>0 = ready dly cycles after strobe, dly<0 = absent
   always @(posedge clk or posedge rst) begin
      if (rst)                 since <= 0;
      else if (io_addr_strobe) since <= 1;
      else if (rsp_valid)      since <= 0;
      else if (since != 0)     since <= since + 1;
   end

   assign io_ready     = stray | ((cur_dly == 0) && io_addr_strobe) | ((cur_dly > 0) && (since == cur_dly));
   assign io_read_data = rd_data;

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      int          dly;
      logic [31:0] rdata;
      logic [31:0] exp_rdata;
      logic        exp_to;
      int          exp_lat;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic issue(input vec_t v, input bit ack);
      int   n;
      int   s_cyc;
      int   n_as, n_rs, n_ws;
      logic bad;
      @(negedge clk);
      cur_dly   = v.dly;
      rd_data   = v.rdata;
      cmd_valid = 1'b1;
      cmd_write = v.wr;
      cmd_addr  = v.addr;
      cmd_be    = v.be;
      cmd_wdata = v.wdata;
      n = 0;
      while (!cmd_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("accept_wait", 32'(n < 20), 32'd1);
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("strobe_latency", 32'(io_addr_strobe), 32'd1);
      s_cyc = cyc;
      n_as = 0; n_rs = 0; n_ws = 0; bad = 1'b0; n = 0;
      while (!rsp_valid && n < 400) begin
         n_as += int'(io_addr_strobe);
         n_rs += int'(io_read_strobe);
         n_ws += int'(io_write_strobe);
         if (io_address !== v.addr || io_byte_enable !== (v.wr ? v.be : 4'hf) ||
             (v.wr && io_write_data !== v.wdata))
            bad = 1'b1;
         @(negedge clk);
         n++;
      end
      chk("rsp_wait", 32'(n < 400), 32'd1);
      chk("addr_strobe_pulses", 32'(n_as), 32'd1);
      chk("read_strobe_pulses", 32'(n_rs), v.wr ? 32'd0 : 32'd1);
      chk("write_strobe_pulses", 32'(n_ws), v.wr ? 32'd1 : 32'd0);
      chk("io_outputs_stable", 32'(bad), 32'd0);
      chk("io_address", io_address, v.addr);
      chk("io_byte_enable", 32'(io_byte_enable), v.wr ? 32'(v.be) : 32'hf);
      chk("rsp_latency", 32'(cyc - s_cyc), 32'(v.exp_lat));
      chk("rsp_rdata", rsp_rdata, v.exp_rdata);
      chk("rsp_timeout", 32'(rsp_timeout), 32'(v.exp_to));
      if (ack) begin
         rsp_ready = 1'b1;
         @(negedge clk);
         rsp_ready = 1'b0;
         chk("rsp_released", 32'(rsp_valid), 32'd0);
         chk("cmd_ready_after_rsp", 32'(cmd_ready), 32'd1);
      end
   endtask

   initial begin
      vec_t v;
      logic bad;
      int   n;

      vecs[0] = '{1'b0, 32'hC000_0010, 4'h0, 32'h0,          0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1};
      vecs[1] = '{1'b1, 32'hC000_0004, 4'h3, 32'h1234_5678,  3, 32'hDEAD_BEEF, 32'h0,         1'b0, 4};
      vecs[2] = '{1'b0, 32'hC000_0020, 4'h0, 32'h0,         -1, 32'h0,         32'hFFFF_FFFF, 1'b1, 256};
      vecs[3] = '{1'b0, 32'hC000_0024, 4'h0, 32'h0,          0, 32'h1357_9BDF, 32'h1357_9BDF, 1'b0, 1};
      vecs[4] = '{1'b0, 32'hC000_0028, 4'h0, 32'h0,        255, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b0, 256};
      vecs[5] = '{1'b1, 32'hC000_0100, 4'hF, 32'hCAFE_F00D,  1, 32'h7777_7777, 32'h0,         1'b0, 2};
      vecs[6] = '{1'b0, 32'hC000_0200, 4'h0, 32'h0,          2, 32'h0000_1234, 32'h0000_1234, 1'b0, 3};

      rst = 1'b1;
      cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_be = '0; cmd_wdata = '0;
      rsp_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("reset_rsp_timeout", 32'(rsp_timeout), 32'd0);
      chk("reset_strobes", {29'd0, io_addr_strobe, io_read_strobe, io_write_strobe}, 32'd0);
      chk("reset_rsp_rdata", rsp_rdata, 32'd0);
      chk("reset_io_address", io_address, 32'd0);
      chk("reset_io_write_data", io_write_data, 32'd0);
      chk("reset_io_byte_enable", 32'(io_byte_enable), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("cmd_ready_after_reset", 32'(cmd_ready), 32'd1);

      for (int i = 0; i < 7; i++) issue(vecs[i], 1'b1);

      // Back-pressure with a second command waiting and stray io_ready
      v = '{1'b0, 32'hC000_0300, 4'h0, 32'h0, 0, 32'h1111_2222, 32'h1111_2222, 1'b0, 1};
      issue(v, 1'b0);
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'hC000_0030;
      stray = 1'b1; rd_data = 32'h9999_9999;
      bad = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (!rsp_valid || rsp_rdata !== 32'h1111_2222 || rsp_timeout || cmd_ready || io_addr_strobe)
            bad = 1'b1;
      end
      chk("backpressure_hold", 32'(bad), 32'd0);
      stray = 1'b0; cur_dly = 0; rd_data = 32'h5555_6666;
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("bp_rsp_released", 32'(rsp_valid), 32'd0);
      chk("bp_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("bp_no_early_strobe", 32'(io_addr_strobe), 32'd0);
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("bp_second_strobe", 32'(io_addr_strobe), 32'd1);
      chk("bp_second_address", io_address, 32'hC000_0030);
      @(negedge clk);
      chk("bp_second_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_second_rdata", rsp_rdata, 32'h5555_6666);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;

      // Stray io_ready pulses while idle
      stray = 1'b1; rd_data = 32'h1234_5678;
      bad = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (rsp_valid || io_addr_strobe) bad = 1'b1;
      end
      stray = 1'b0;
      chk("idle_stray_ready_ignored", 32'(bad), 32'd0);

      // Reset during WAIT
      @(negedge clk);
      cur_dly = -1;
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'hC000_0040;
      n = 0;
      while (!cmd_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("rst_accept_wait", 32'(n < 20), 32'd1);
      @(negedge clk);
      cmd_valid = 1'b0;
      repeat (5) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_strobes", {29'd0, io_addr_strobe, io_read_strobe, io_write_strobe}, 32'd0);
      chk("async_rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("async_rst_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("async_rst_io_address", io_address, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      bad = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (rsp_valid || io_addr_strobe) bad = 1'b1;
      end
      chk("aborted_no_response", 32'(bad), 32'd0);
      chk("cmd_ready_after_abort", 32'(cmd_ready), 32'd1);

      v = '{1'b0, 32'hC000_0050, 4'h0, 32'h0, 0, 32'h0BAD_CAFE, 32'h0BAD_CAFE, 1'b0, 1};
      issue(v, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
